// File: rtl/uart_tx_arbiter.sv
// Round-robin front end for the shared UART transmitter: grants one byte at a time
// from four requesters, sequences tx_start off tx_busy and owns the baud select.
module uart_tx_arbiter #(
    parameter int         START_TIMEOUT = 1023,
    parameter logic [1:0] DEFAULT_SEL   = 2'b01
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  req_valid,
    input  logic [31:0] req_data,
    output logic [3:0]  req_ready,
    input  logic        cfg_we,
    input  logic [1:0]  cfg_sel,
    input  logic        err_clr,
    output logic [1:0]  tx_sel,
    output logic        tx_start,
    output logic [7:0]  tx_data,
    input  logic        tx_busy,
    output logic [1:0]  grant_id,
    output logic        active,
    output logic        done,
    output logic        err_timeout
);

    typedef enum logic [1:0] {IDLE, START, WAIT_BUSY, GAP} state_t;

    localparam int CNT_W = $clog2(START_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(START_TIMEOUT);

    state_t           state;
    logic [1:0]       rr_ptr;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       pick;

    // Lowest offset from ptr wins, so scan offsets high-to-low and let later hits override.
    function automatic logic [1:0] rr_pick(input logic [3:0] valid, input logic [1:0] ptr);
        logic [1:0] idx;
        rr_pick = ptr;
        for (int k = 3; k >= 0; k--) begin
            idx = ptr + 2'(k);
            if (valid[idx]) rr_pick = idx;
        end
    endfunction

    assign pick = rr_pick(req_valid, rr_ptr);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            tx_sel      <= DEFAULT_SEL;
            tx_start    <= 1'b0;
            tx_data     <= 8'h00;
            req_ready   <= 4'b0000;
            grant_id    <= 2'd0;
            active      <= 1'b0;
            done        <= 1'b0;
            err_timeout <= 1'b0;
            rr_ptr      <= 2'd0;
            cnt         <= '0;
        end else begin
            req_ready <= 4'b0000;
            done      <= 1'b0;
            // A timeout later in this block overrides a simultaneous clear.
            if (err_clr) err_timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (cfg_we) begin
                        tx_sel <= cfg_sel;
                    end else if (|req_valid) begin
                        tx_data   <= req_data[{pick, 3'b000} +: 8];
                        grant_id  <= pick;
                        req_ready <= 4'b0001 << pick;
                        tx_start  <= 1'b1;
                        cnt       <= '0;
                        rr_ptr    <= pick + 2'd1;
                        active    <= 1'b1;
                        state     <= START;
                    end
                end
                START: begin
                    cnt <= cnt + CNT_W'(1);
                    if (tx_busy) begin
                        tx_start <= 1'b0;
                        state    <= WAIT_BUSY;
                    end else if (cnt == TIMEOUT_CNT) begin
                        tx_start    <= 1'b0;
                        err_timeout <= 1'b1;
                        active      <= 1'b0;
                        state       <= IDLE;
                    end
                end
                WAIT_BUSY: begin
                    if (!tx_busy) begin
                        done  <= 1'b1;
                        state <= GAP;
                    end
                end
                GAP: begin
                    active <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a behavioural tx model that raises busy
// a few cycles after tx_start and holds it for frame_len cycles.
module tb_uart_tx_arbiter;

    localparam int TMO = 1023;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic        cfg_we;
    logic [1:0]  cfg_sel;
    logic        err_clr;
    logic [1:0]  tx_sel;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        tx_busy;
    logic [1:0]  grant_id;
    logic        active;
    logic        done;
    logic        err_timeout;

    int total = 0;
    int bad = 0;

    uart_tx_arbiter #(.START_TIMEOUT(TMO), .DEFAULT_SEL(2'b01)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .cfg_we(cfg_we), .cfg_sel(cfg_sel), .err_clr(err_clr),
        .tx_sel(tx_sel), .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy),
        .grant_id(grant_id), .active(active), .done(done), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    // Behavioural transmitter
    logic tx_en;
    int   frame_len;
    int   phase;
    int   dly;
    always @(posedge clk) begin
        if (!reset) begin
            tx_busy <= 1'b0;
            phase   <= 0;
            dly     <= 0;
        end else begin
            case (phase)
                0: if (tx_start && tx_en) begin phase <= 1; dly <= 2; end
                1: if (dly == 0) begin tx_busy <= 1'b1; phase <= 2; dly <= frame_len - 1; end
                   else dly <= dly - 1;
                default: if (dly == 0) begin tx_busy <= 1'b0; phase <= 0; end
                         else dly <= dly - 1;
            endcase
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic expired(input string name);
        total++;
        bad++;
        $display("FAIL %s: wait bound expired, got no event expected event", name);
    endtask

    typedef struct {
        logic [3:0] valid;
        logic [1:0] grant;
        logic [7:0] data;
    } vec_t;

    vec_t vecs[14];

    initial begin
        int  n;
        bit  hit;

        // 8 all-valid grants from pointer 0, then mixed patterns exercising the pointer
        for (int i = 0; i < 8; i++) begin
            vecs[i].valid = 4'b1111;
            vecs[i].grant = 2'(i % 4);
            vecs[i].data  = 8'h10 + 8'(i % 4) * 8'h11;
        end
        vecs[8]  = '{4'b1010, 2'd1, 8'h21};
        vecs[9]  = '{4'b1010, 2'd3, 8'h43};
        vecs[10] = '{4'b0001, 2'd0, 8'h10};
        vecs[11] = '{4'b0110, 2'd1, 8'h21};
        vecs[12] = '{4'b0110, 2'd2, 8'h32};
        vecs[13] = '{4'b1001, 2'd3, 8'h43};

        reset = 1'b0; req_valid = 4'b0; req_data = 32'h0; cfg_we = 1'b0;
        cfg_sel = 2'b00; err_clr = 1'b0; tx_en = 1'b1; frame_len = 100;

        // Reset values
        repeat (10) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_tx_sel", 32'(tx_sel), 32'h1);
        chk("rst_tx_start", 32'(tx_start), 32'h0);
        chk("rst_tx_data", 32'(tx_data), 32'h0);
        chk("rst_req_ready", 32'(req_ready), 32'h0);
        chk("rst_grant_id", 32'(grant_id), 32'h0);
        chk("rst_active", 32'(active), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_err", 32'(err_timeout), 32'h0);

        // Single transfer on channel 0
        req_data = 32'h000000A5;
        req_valid = 4'b0001;
        @(negedge clk);
        chk("single_ready", 32'(req_ready), 32'h1);
        chk("single_data", 32'(tx_data), 32'hA5);
        chk("single_start", 32'(tx_start), 32'h1);
        chk("single_active", 32'(active), 32'h1);
        req_valid = 4'b0000;
        @(negedge clk);
        chk("single_ready_pulse", 32'(req_ready), 32'h0);
        hit = 0;
        for (int i = 0; i < 20 && !hit; i++) begin
            if (tx_busy) hit = 1; else @(negedge clk);
        end
        if (!hit) expired("single_busy");
        chk("single_start_held", 32'(tx_start), 32'h1);
        @(negedge clk);
        chk("single_start_drop", 32'(tx_start), 32'h0);
        hit = 0;
        for (int i = 0; i < 300 && !hit; i++) begin
            @(negedge clk);
            if (done) hit = 1;
        end
        if (!hit) expired("single_done");
        @(negedge clk);
        chk("single_done_pulse", 32'(done), 32'h0);
        chk("single_idle", 32'(active), 32'h0);

        // Fresh pointer, then the vector table
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        frame_len = 10;
        req_data = 32'h43322110;
        for (int v = 0; v < 14; v++) begin
            req_valid = vecs[v].valid;
            hit = 0;
            for (int i = 0; i < 200 && !hit; i++) begin
                @(negedge clk);
                if (req_ready != 4'b0) hit = 1;
            end
            if (!hit) expired($sformatf("vec%0d_grant", v));
            chk($sformatf("vec%0d_ready", v), 32'(req_ready), 32'(4'b0001 << vecs[v].grant));
            chk($sformatf("vec%0d_grant_id", v), 32'(grant_id), 32'(vecs[v].grant));
            chk($sformatf("vec%0d_data", v), 32'(tx_data), 32'(vecs[v].data));
        end
        req_valid = 4'b0000;
        n = 0;
        while (active && n < 200) begin @(negedge clk); n++; end
        if (active) expired("vec_drain");

        // Start timeout with busy never rising
        tx_en = 1'b0;
        req_valid = 4'b0001;
        @(negedge clk);
        chk("tmo_start", 32'(tx_start), 32'h1);
        req_valid = 4'b0000;
        repeat (TMO) @(negedge clk);
        chk("tmo_err_early", 32'(err_timeout), 32'h0);
        chk("tmo_start_held", 32'(tx_start), 32'h1);
        @(negedge clk);
        chk("tmo_err", 32'(err_timeout), 32'h1);
        chk("tmo_start_drop", 32'(tx_start), 32'h0);
        chk("tmo_idle", 32'(active), 32'h0);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        chk("tmo_clr", 32'(err_timeout), 32'h0);

        // Timeout coinciding with err_clr keeps the flag set
        req_valid = 4'b0001;
        @(negedge clk);
        req_valid = 4'b0000;
        repeat (TMO) @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        chk("tmo_clr_race", 32'(err_timeout), 32'h1);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        chk("tmo_clr2", 32'(err_timeout), 32'h0);

        // Config wins over a simultaneous request; grant follows a cycle later
        tx_en = 1'b1;
        frame_len = 20;
        cfg_we = 1'b1; cfg_sel = 2'b11; req_valid = 4'b0100;
        @(negedge clk);
        cfg_we = 1'b0;
        chk("cfg_sel", 32'(tx_sel), 32'h3);
        chk("cfg_no_grant", 32'(req_ready), 32'h0);
        @(negedge clk);
        chk("cfg_grant_ready", 32'(req_ready), 32'h4);
        chk("cfg_grant_id", 32'(grant_id), 32'h2);
        chk("cfg_grant_data", 32'(tx_data), 32'h32);
        req_valid = 4'b0000;
        hit = 0;
        for (int i = 0; i < 20 && !hit; i++) begin
            @(negedge clk);
            if (tx_busy && !tx_start) hit = 1;
        end
        if (!hit) expired("cfg_wait_busy");
        cfg_we = 1'b1; cfg_sel = 2'b00;
        @(negedge clk);
        cfg_we = 1'b0;
        chk("cfg_ignored", 32'(tx_sel), 32'h3);

        // Reset mid-WAIT_BUSY
        reset = 1'b0;
        @(negedge clk);
        chk("midrst_start", 32'(tx_start), 32'h0);
        chk("midrst_active", 32'(active), 32'h0);
        chk("midrst_err", 32'(err_timeout), 32'h0);
        chk("midrst_sel", 32'(tx_sel), 32'h1);
        reset = 1'b1;
        req_valid = 4'b1111;
        @(negedge clk);
        chk("midrst_ptr", 32'(grant_id), 32'h0);
        chk("midrst_ready", 32'(req_ready), 32'h1);
        req_valid = 4'b0000;
        repeat (5) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin controller that shares the single `tx` UART transmitter among four byte requesters and owns its baud-rate configuration. It accepts one byte at a time from the requesters and drives the `tx_start`/`tx_data`/`sel` inputs of `tx`. It sequences each transfer off `tx_busy` and flags a transmitter that never starts. It sits between on-chip producers (command, status and debug channels) and the `tx` instance.

## Interface

- `START_TIMEOUT`, default 1023: cycles in START without `tx_busy` rising before abort.
- `DEFAULT_SEL`, default 2'b01: baud select loaded at reset.

- `clk`  in  1  system clock, all logic on rising edge
- `reset`  in  1  synchronous, active-low: reset==0 at a rising edge resets the block
- `req_valid`  in  4  channel i has a byte to send
- `req_data`  in  32  channel i byte at [8i+7:8i]
- `req_ready`  out  4  one-cycle pulse, channel i byte accepted
- `cfg_we`  in  1  write `cfg_sel` into the baud-select register
- `cfg_sel`  in  2  new baud select
- `err_clr`  in  1  clears `err_timeout`
- `tx_sel`  out  2  to `tx.sel`
- `tx_start`  out  1  to `tx.tx_start`
- `tx_data`  out  8  to `tx.tx_data`
- `tx_busy`  in  1  from `tx.tx_busy`
- `grant_id`  out  2  channel owning the current or last transfer
- `active`  out  1  high in any state other than IDLE
- `done`  out  1  one-cycle pulse on transfer completion
- `err_timeout`  out  1  sticky start-timeout flag

## Operation

- FSM states: IDLE, START, WAIT_BUSY, GAP. All outputs are registered.
- Reset values:
  - state=IDLE, `tx_sel`=DEFAULT_SEL, `tx_start`=0, `tx_data`=0, `req_ready`=0.
  - `grant_id`=0, `active`=0, `done`=0, `err_timeout`=0.
  - RR pointer=0, timeout counter=0.
- IDLE:
  - If `cfg_we`=1: load `tx_sel`<=`cfg_sel`. Arbitration is skipped this cycle, so config wins over requests.
  - Otherwise, if any `req_valid` is set: choose the first set bit, searching from the RR pointer upward mod 4.
  - On a grant: latch that byte into `tx_data`, set `grant_id`, pulse `req_ready[i]`, set `tx_start`=1, clear the counter, go to START.
  - RR pointer <= granted index + 1 (mod 4).
- START:
  - `tx_start` is held at 1 and the counter increments.
  - If `tx_busy`=1: `tx_start`<=0, go to WAIT_BUSY.
  - Else if counter==START_TIMEOUT: `tx_start`<=0, `err_timeout`<=1, go to IDLE. The byte is dropped and there is no retry.
- WAIT_BUSY: when `tx_busy`=0, pulse `done` and go to GAP.
- GAP: one idle cycle with `tx_start`=0, so `tx` sees a start-level edge per byte. Then go to IDLE.
- `cfg_we` outside IDLE is ignored. Software must poll `active`=0 before writing. `tx_sel` therefore never changes mid-frame.
- `err_clr`:
  - Clears `err_timeout` in any state.
  - A timeout and `err_clr` in the same cycle leave `err_timeout`=1.
- Requester rule: hold `req_valid`/`req_data` stable until `req_ready[i]` is seen. Drop `req_valid` or change the byte on the following cycle.
- Back-to-back requests are safe: the arbiter does not resample until it returns to IDLE.

## Timing

- Grant latency: valid sampled at edge T in IDLE → `req_ready[i]`, `tx_start`, `tx_data` and `grant_id` are valid after edge T.
- `tx_start` stays high until the cycle after `tx_busy` is first sampled high.
- Minimum per-byte overhead beyond the `tx` frame is 4 cycles: IDLE grant, START, WAIT exit, GAP.
- Maximum turnaround between grants is frame + 4 cycles.
- Timeout path: `err_timeout` rises START_TIMEOUT+1 cycles after `tx_start` rose.
- Reset during START or WAIT_BUSY: all outputs return to reset values at that edge and `tx_start` drops immediately. The in-flight byte is abandoned. `tx` is reset by the same net.
- All 4 channels valid continuously: grants run 0,1,2,3,0,… with no starvation.

## Test plan

- Reset with `reset`=0 for 10 cycles, then release → all outputs at reset values, `tx_sel`=2'b01, `active`=0.
- `req_valid`=4'b0001, `req_data`[7:0]=8'hA5, behavioral `tx` asserts busy 3 cycles after start for 100 cycles → `req_ready`=4'b0001 pulse, `tx_data`=8'hA5, `tx_start` high until busy is seen, one `done` pulse, return to IDLE.
- All four channels valid with bytes 8'h10/8'h21/8'h32/8'h43, held for 8 transfers → grant order 0,1,2,3,0,1,2,3 and matching `tx_data` sequence.
- `tx_busy` tied 0, single request → `err_timeout`=1 exactly START_TIMEOUT+1 cycles after `tx_start` rose, `tx_start`=0, IDLE. Then `err_clr` pulse → flag 0.
- `cfg_we`=1 with `cfg_sel`=2'b11 in the same cycle as `req_valid`=4'b0100 → `tx_sel`=2'b11 first, grant one cycle later. `cfg_we` during WAIT_BUSY → `tx_sel` unchanged.
- `reset`=0 asserted mid-WAIT_BUSY → next cycle `tx_start`=0, `active`=0, RR pointer=0, `err_timeout`=0.
